ipbase_arbit_wrrcore: RTL
=========================

// Module: ipbase_arbit_wrrcore
// PURPOSE
//  Registered weighted round-robin arbiter with grant hold and optional packet lock.
//  Rotates a one-hot sequential priority across NUM requesters.
//  Each winner keeps the grant for up to weight[i] transfer units, then the pointer moves on.
//  Sits in front of shared output queues / NACK pipes where requesters send multi-beat units.
// PARAMETERS
//  NUM       4  number of requesters (>=2)
//  WW        4  per-requester weight width; credit counter width
//  PKT_MODE  1  1: unit = packet (ends on ilast); 0: unit = single beat
// PORTS
//  clk      in   1        clock
//  rst_n    in   1        asynchronous active-low reset
//  iq       in   NUM      request vector, bit i = requester i
//  ilast    in   NUM      last-beat flag per requester (ignored when PKT_MODE=0)
//  weight   in   NUM*WW   weight of requester i at [i*WW +: WW]
//  ack      in   1        downstream accepts current beat
//  og       out  NUM      registered one-hot grant
//  og_vld   out  1        |og
//  og_id    out  clog2(NUM) binary index of og (0 when og=0)
// BEHAVIOUR
//  Reset (async, rst_n=0): FSM=ARB, og=0, og_vld=0, og_id=0, prio=1 (bit0), credit=0, in_pkt=0.
//  State ARB
//   - Combinational pick: first set bit of iq at or cyclically above the one-hot prio
//     (seq-prio rotate-and-select).
//   - If iq!=0: load og=pick, credit=weight[pick] (0 treated as 1), go GRANT.
//     og is visible the cycle after iq is sampled (latency 1).
//   - If iq==0: stay ARB, og=0.
//  State GRANT (g = granted index)
//   - Beat transfer = ack & iq[g].
//   - Unit end:
//     - PKT_MODE=1: transfer with ilast[g]=1.
//     - PKT_MODE=0: every transfer.
//   - in_pkt sets on a transfer with ilast[g]=0 and clears on unit end.
//     Tracked only when PKT_MODE=1.
//   - On unit end, credit decrements.
//     - If credit reaches 0, end the turn: prio = og rotated left by 1 (bit NUM-1 wraps to bit0),
//       og=0, go ARB.
//     - Otherwise stay GRANT.
//   - Forfeit: iq[g]=0 while in_pkt=0 ends the turn with the same prio rotation.
//   - iq[g]=0 with in_pkt=1 holds the grant (bubble); the packet is never split.
//   - ack with iq[g]=0 is not a transfer.
//   - One ARB bubble cycle always separates consecutive grants, including the same requester
//     regaining the grant.
//  Weights are sampled only at grant load; changes mid-turn take effect next turn.
//  Requests from non-granted requesters never affect og during GRANT.
//  Credit arithmetic: WW-bit unsigned, no underflow (decrement only when credit>=1).
//  Async reset mid-packet forces og=0 immediately and restarts priority at bit0.
//  og is always one-hot or zero; og_vld==|og; og_id==index(og).
// TESTING
//  T1 rst_n=0 with iq=1111 -> og=0, og_vld=0. After release, cycle 1 og=0001.
//  T2 NUM=4, PKT_MODE=0, all weights 1, iq=1111, ack=1 -> og sequence 0001,0,0010,0,0100,0,1000,0,0001.
//  T3 PKT_MODE=0, weight0=3, weight1=1, iq=0011, ack=1 -> og=0001 for 3 cycles, 0, 0010 for 1, 0, 0001 again.
//  T4 PKT_MODE=1, req2 sends 4 beats (ilast on 4th), ack=1010..., iq2 low 1 cycle mid-packet,
//     iq=1111 -> og=0100 held through all 4 transfers, no switch; next grant is 1000.
//  T5 weight1=0, iq=0010 -> one unit granted, then rotate (same as weight 1).
//  T6 rst_n pulsed low mid-packet on req3 -> og=0 same cycle. After release with iq=1001 -> og=0001.

Source files
------------

// File: rtl/ipbase_arbit_wrrcore.sv
// Weighted round-robin arbiter: registered one-hot grant, per-requester credit,
// grant hold across packets and a one-cycle arbitration bubble between turns.
module ipbase_arbit_wrrcore #(
  parameter int NUM      = 4,
  parameter int WW       = 4,
  parameter int PKT_MODE = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM-1:0]               iq,
  input  logic [NUM-1:0]               ilast,
  input  logic [NUM*WW-1:0]            weight,
  input  logic                         ack,
  output logic [NUM-1:0]               og,
  output logic                         og_vld,
  output logic [$clog2(NUM)-1:0]       og_id,
  output logic                         state_dbg
);

  localparam int IW = $clog2(NUM);

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t          state, state_n;
  logic [NUM-1:0]  og_n;
  logic [IW-1:0]   id_n;
  logic [WW-1:0]   credit, credit_n;
  logic [NUM-1:0]  prio, prio_n;
  logic            in_pkt, in_pkt_n;

  logic [IW-1:0]   prio_idx;
  logic [IW-1:0]   pick_idx;
  logic [IW:0]     scan_pos;
  logic            pick_found;
  logic [WW-1:0]   pick_w;

  logic            iq_g;
  logic            ilast_g;
  logic            xfer;
  logic            unit_end;
  logic            end_turn;

  // Rotate-and-select: scan from the priority position upwards, wrapping at NUM.
  always_comb begin
    prio_idx   = '0;
    pick_idx   = '0;
    pick_found = 1'b0;
    scan_pos   = '0;
    for (int i = 0; i < NUM; i++) begin
      if (prio[i]) prio_idx = IW'(i);
    end
    for (int k = 0; k < NUM; k++) begin
      scan_pos = {1'b0, prio_idx} + (IW+1)'(k);
      if (scan_pos >= (IW+1)'(NUM)) scan_pos = scan_pos - (IW+1)'(NUM);
      if (!pick_found && iq[scan_pos[IW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = scan_pos[IW-1:0];
      end
    end
  end

  assign pick_w   = weight[int'(pick_idx)*WW +: WW];
  assign iq_g     = iq[og_id];
  assign ilast_g  = ilast[og_id];
  assign xfer     = ack & iq_g;
  assign unit_end = xfer & ((PKT_MODE != 0) ? ilast_g : 1'b1);

  always_comb begin
    state_n  = state;
    og_n     = og;
    id_n     = og_id;
    credit_n = credit;
    prio_n   = prio;
    in_pkt_n = in_pkt;
    end_turn = 1'b0;
    case (state)
      ST_ARB: begin
        if (|iq) begin
          og_n     = NUM'(1) << pick_idx;
          id_n     = pick_idx;
          credit_n = (pick_w == '0) ? WW'(1) : pick_w;
          in_pkt_n = 1'b0;
          state_n  = ST_GRANT;
        end else begin
          og_n = '0;
          id_n = '0;
        end
      end
      ST_GRANT: begin
        if (unit_end) begin
          in_pkt_n = 1'b0;
          if (credit != '0) credit_n = credit - WW'(1);
          if (credit <= WW'(1)) end_turn = 1'b1;
        end else if (xfer && (PKT_MODE != 0) && !ilast_g) begin
          in_pkt_n = 1'b1;
        end
        // A dropped request only gives up the grant between packets.
        if (!iq_g && !in_pkt) end_turn = 1'b1;
        if (end_turn) begin
          og_n     = '0;
          id_n     = '0;
          prio_n   = {og[NUM-2:0], og[NUM-1]};
          in_pkt_n = 1'b0;
          state_n  = ST_ARB;
        end
      end
      default: state_n = ST_ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_ARB;
      og     <= '0;
      og_id  <= '0;
      credit <= '0;
      prio   <= NUM'(1);
      in_pkt <= 1'b0;
    end else begin
      state  <= state_n;
      og     <= og_n;
      og_id  <= id_n;
      credit <= credit_n;
      prio   <= prio_n;
      in_pkt <= in_pkt_n;
    end
  end

  assign og_vld    = |og;
  assign state_dbg = state;

endmodule
